riscv_irq_exc_ctrl: RTL
=======================

RISCV_IRQ_EXC_CTRL -- requirements
Module: riscv_irq_exc_ctrl

Interface
REQ-001 Parameter N_IRQ, 32, number of interrupt lines; legal range 1..32.
REQ-002 Parameter EDGE_MASK, 32'h0, per-line mode; bit i = 1 makes line i edge-triggered (rising), 0 makes it level-triggered.
REQ-003 clk  input  1  core clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_o  output  1  exception/interrupt request to controller.
REQ-006 ack_i  input  1  controller accepts the request.
REQ-007 trap_o  output  1  trap to debug unit.
REQ-008 pc_mux_o  output  2  exception PC select (EXC_PC_IRQ/ECALL/ILLINSN/LOAD/STORE codes).
REQ-009 vec_pc_mux_o  output  5  vector index, equal to cause_o[4:0].
REQ-010 irq_i  input  N_IRQ  interrupt lines.
REQ-011 irq_mask_i  input  N_IRQ  per-line enable; 1 = enabled.
REQ-012 irq_enable_i  input  1  global interrupt enable from CSR.
REQ-013 ebrk_insn_i, illegal_insn_i, ecall_insn_i, lsu_load_err_i, lsu_store_err_i  input  1 each  decoder/LSU events.
REQ-014 cause_o  output  6  cause; bit 5 = interrupt, bits 4:0 = code or line id.
REQ-015 save_cause_o  output  1  one-cycle strobe for CSR cause capture.
REQ-016 irq_ack_o  output  1  one-cycle strobe: an interrupt was accepted.
REQ-017 irq_id_o  output  5  id of the accepted interrupt, valid with irq_ack_o.
REQ-018 dbg_settings_i  input  DBG_SETS_W  debug trap enables.

Function
REQ-019 Pending vector: level line i pending = irq_i[i]; edge line i sets a sticky pending bit on a 0->1 transition of irq_i (registered previous value) and clears it only on acceptance of id i.
REQ-020 Active vector = pending & irq_mask_i, qualified by irq_enable_i; irq_req = OR of active vector.
REQ-021 Interrupt arbitration: fixed priority, lowest index wins; cause = {1'b1, id}.
REQ-022 Exception priority, highest first: store error (6'h07), load error (6'h05), illegal (6'h02), ecall (6'h0B), interrupt; ebreak forces cause 6'h03 without raising req_o.
REQ-023 req_int = store | load | illegal | ecall | irq_req.
REQ-024 FSM states IDLE, WAIT_ACK; reset state IDLE.
REQ-025 IDLE: req_o = req_int; req_int & ack_i -> save_cause_o = 1, stay IDLE; req_int & !ack_i -> WAIT_ACK.
REQ-026 WAIT_ACK: req_o = 1; ack_i -> save_cause_o = 1, go IDLE; otherwise hold.
REQ-027 On entry to request (IDLE & req_int) cause and pc_mux are registered; in IDLE with req_int outputs bypass to live values, otherwise registered values; ebreak always bypasses cause.
REQ-028 Latched cause is held in WAIT_ACK even if the source deasserts or a higher-priority event arrives.
REQ-029 irq_ack_o = save_cause_o & cause_o[5]; irq_id_o = cause_o[4:0]; the edge pending bit of that id clears on the same clock edge.
REQ-030 New edge on a line in the cycle its pending bit is cleared: set wins (bit stays 1).
REQ-031 trap_o = SSTE | ecall&ECALL | (load|store)&ELSU | ebrk&EBRK | illegal&EILL | irq_req&IRQ.
REQ-032 Unused upper cause/id bits for N_IRQ < 32 are zero; lines >= N_IRQ do not exist.

Reset
REQ-033 On rst_n low: FSM IDLE, latched cause 0, latched pc_mux 0, all pending bits 0, edge history 0.
REQ-034 Reset values of outputs (with all inputs 0): req_o 0, save_cause_o 0, irq_ack_o 0, irq_id_o 0, cause_o 0, pc_mux_o 0, trap_o 0.
REQ-035 Reset asserted mid-request drops req_o immediately and discards pending edge interrupts.

Configuration
REQ-036 Macro RISCV_IRQ_EDGE_EN: defined -> edge logic per EDGE_MASK per REQ-019/029/030; undefined -> EDGE_MASK ignored, all lines level-triggered, no pending/history flops.

Verification
REQ-037 irq_i=32'h0000_0030, mask all 1, enable=1, ack_i=1 same cycle -> req_o=1, cause_o=6'h24, save_cause_o=1, irq_ack_o=1, irq_id_o=4.
REQ-038 lsu_store_err_i and illegal_insn_i together, ack_i delayed 3 cycles -> cause_o=6'h07 held all 4 cycles, save_cause_o single pulse in 4th cycle.
REQ-039 RISCV_IRQ_EDGE_EN, EDGE_MASK bit 2, one-cycle pulse on irq_i[2], ack 5 cycles later -> req_o held, cause 6'h22, pending cleared after ack, req_o 0 next cycle.
REQ-040 irq_i[1]=1 with irq_mask_i[1]=0 or irq_enable_i=0 -> req_o=0, trap_o=0 with DBG IRQ enabled.
REQ-041 Request pending in WAIT_ACK, rst_n pulsed low -> req_o=0 asynchronously, FSM IDLE, cause_o=0 after release.
REQ-042 N_IRQ=8, irq_i=8'h80 -> cause_o=6'h27; ebrk_insn_i alone -> cause_o=6'h03, req_o=0.

Source files
------------

// File: rtl/riscv_irq_exc_ctrl.sv
// Interrupt/exception controller: prioritises exceptions and interrupts and holds the cause until the core acks.
// Optional macro RISCV_IRQ_EDGE_EN enables rising-edge sticky pending bits for lines selected by EDGE_MASK.
module riscv_irq_exc_ctrl #(
  parameter int          N_IRQ      = 32,
  parameter logic [31:0] EDGE_MASK  = 32'h0,
  parameter int          DBG_SETS_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  req_o,
  input  logic                  ack_i,
  output logic                  trap_o,
  output logic [1:0]            pc_mux_o,
  output logic [4:0]            vec_pc_mux_o,
  input  logic [N_IRQ-1:0]      irq_i,
  input  logic [N_IRQ-1:0]      irq_mask_i,
  input  logic                  irq_enable_i,
  input  logic                  ebrk_insn_i,
  input  logic                  illegal_insn_i,
  input  logic                  ecall_insn_i,
  input  logic                  lsu_load_err_i,
  input  logic                  lsu_store_err_i,
  output logic [5:0]            cause_o,
  output logic                  save_cause_o,
  output logic                  irq_ack_o,
  output logic [4:0]            irq_id_o,
  input  logic [DBG_SETS_W-1:0] dbg_settings_i,
  output logic                  dbg_state
);

  // Handshake: req_o stays high from the first cycle a request is seen until a cycle with ack_i high;
  // that cycle is the transfer (save_cause_o pulses) and the cause shown in it is the one accepted.

  localparam int DBG_SSTE  = 0;
  localparam int DBG_ECALL = 1;
  localparam int DBG_ELSU  = 2;
  localparam int DBG_EBRK  = 3;
  localparam int DBG_EILL  = 4;
  localparam int DBG_IRQ   = 5;

  localparam logic [1:0] EXC_PC_ILLINSN = 2'b00;
  localparam logic [1:0] EXC_PC_ECALL   = 2'b01;
  localparam logic [1:0] EXC_PC_LOAD    = 2'b10;
  localparam logic [1:0] EXC_PC_STORE   = 2'b10;
  localparam logic [1:0] EXC_PC_IRQ     = 2'b11;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t             state_q, state_d;
  logic [N_IRQ-1:0]   pending, active;
  logic               irq_req, req_int, bypass;
  logic [4:0]         irq_id;
  logic [5:0]         cause_int, cause_q;
  logic [1:0]         pc_int, pc_q;

`ifdef RISCV_IRQ_EDGE_EN
  localparam logic [N_IRQ-1:0] EDGE = EDGE_MASK[N_IRQ-1:0];
  logic [N_IRQ-1:0] irq_q, edge_pend_q, clr;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) clr[i] = irq_ack_o && (irq_id_o == 5'(i));
  end

  // A fresh rising edge is OR-ed in after the clear, so it survives a same-cycle acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q       <= '0;
      edge_pend_q <= '0;
    end else begin
      irq_q       <= irq_i;
      edge_pend_q <= ((edge_pend_q & ~clr) | (irq_i & ~irq_q)) & EDGE;
    end
  end

  assign pending = (irq_i & ~EDGE) | edge_pend_q;
`else
  logic unused_edge_mask;
  assign unused_edge_mask = ^EDGE_MASK;
  assign pending          = irq_i;
`endif

  assign active  = irq_enable_i ? (pending & irq_mask_i) : '0;
  assign irq_req = |active;

  always_comb begin
    irq_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) irq_id = 5'(i);
    end
  end

  always_comb begin
    cause_int = {1'b1, irq_id};
    pc_int    = EXC_PC_IRQ;
    if (lsu_store_err_i) begin
      cause_int = 6'h07;
      pc_int    = EXC_PC_STORE;
    end else if (lsu_load_err_i) begin
      cause_int = 6'h05;
      pc_int    = EXC_PC_LOAD;
    end else if (illegal_insn_i) begin
      cause_int = 6'h02;
      pc_int    = EXC_PC_ILLINSN;
    end else if (ecall_insn_i) begin
      cause_int = 6'h0B;
      pc_int    = EXC_PC_ECALL;
    end
  end

  assign req_int = lsu_store_err_i | lsu_load_err_i | illegal_insn_i | ecall_insn_i | irq_req;

  always_comb begin
    state_d      = state_q;
    req_o        = 1'b0;
    save_cause_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_o = req_int;
        if (req_int) begin
          if (ack_i) save_cause_o = 1'b1;
          else       state_d      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        req_o = 1'b1;
        if (ack_i) begin
          save_cause_o = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_int) begin
        cause_q <= cause_int;
        pc_q    <= pc_int;
      end
    end
  end

  // The cycle that raises a request shows live values; afterwards the latched ones are frozen.
  assign bypass       = (state_q == IDLE) && req_int;
  assign cause_o      = ebrk_insn_i ? 6'h03 : (bypass ? cause_int : cause_q);
  assign pc_mux_o     = bypass ? pc_int : pc_q;
  assign vec_pc_mux_o = cause_o[4:0];
  assign irq_ack_o    = save_cause_o & cause_o[5];
  assign irq_id_o     = cause_o[4:0];
  assign dbg_state    = state_q;

  assign trap_o = dbg_settings_i[DBG_SSTE]
                | (ecall_insn_i & dbg_settings_i[DBG_ECALL])
                | ((lsu_load_err_i | lsu_store_err_i) & dbg_settings_i[DBG_ELSU])
                | (ebrk_insn_i & dbg_settings_i[DBG_EBRK])
                | (illegal_insn_i & dbg_settings_i[DBG_EILL])
                | (irq_req & dbg_settings_i[DBG_IRQ]);

endmodule
